sc_matrix_decoder: RTL and testbench

SC_MATRIX_DECODER -- requirements
Module: sc_matrix_decoder

---
 rtl/sc_pkg.sv | 15 +
 rtl/sc_bit_counter.sv | 37 +++
 rtl/sc_matrix_decoder.sv | 124 ++++++++++++
 tb/tb_sc_matrix_decoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared FSM state type and counter width helper for the stochastic matrix decoder
package sc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } sc_state_e;

  // One extra bit over LENGTH_LOG2 so a window of all ones reaches N without wrapping.
  function automatic int cnt_width(input int length_log2);
    return length_log2 + 1;
  endfunction

endpackage

// File: rtl/sc_bit_counter.sv
// rtl/sc_bit_counter.sv - single element ones-counter with synchronous clear and enable
module sc_bit_counter #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             bit_in,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear wins over counting; a beat only adds when its stochastic bit is set.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && bit_in) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sc_matrix_decoder.sv
// rtl/sc_matrix_decoder.sv - stochastic bitstream to matrix decoder; SC_DECODER_BIPOLAR_EN selects signed 2*count-N output
module sc_matrix_decoder
  import sc_pkg::*;
#(
  parameter int BATCH_SIZE      = 4,
  parameter int OUTPUT_FEATURES = 4,
  parameter int LENGTH_LOG2     = 8,
  localparam int CW             = cnt_width(LENGTH_LOG2),
`ifdef SC_DECODER_BIPOLAR_EN
  localparam int W              = CW + 1,
`else
  localparam int W              = CW,
`endif
  localparam int NE             = BATCH_SIZE * OUTPUT_FEATURES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [NE-1:0] streamData,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NE*W-1:0] outData
);

  localparam int N = 1 << LENGTH_LOG2;

  sc_state_e       state_q, state_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [NE*W-1:0] out_q;
  logic [NE*W-1:0] field_all;
  logic            clr;
  logic            cnt_en;
  logic            last_beat;

  assign cnt_en    = (state_q == ST_COUNT) && in_valid;
  assign last_beat = cnt_en && (beat_q == CW'(N - 1));

  // Next-state logic; clr restarts a window from IDLE or straight out of a DONE handshake.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (last_beat) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          if (start) begin
            clr     = 1'b1;
            state_d = ST_COUNT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Beat counter tracks accepted beats within the current window.
  always_comb begin
    beat_d = beat_q;
    if (clr) begin
      beat_d = '0;
    end else if (cnt_en) begin
      beat_d = beat_q + CW'(1);
    end
  end

  // State, beat counter and output latch; outData captures only on the final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (last_beat) begin
        out_q <= field_all;
      end
    end
  end

  for (genvar i = 0; i < NE; i++) begin : g_elem
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_final;

    sc_bit_counter #(
      .WIDTH (CW)
    ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clr),
      .enable (cnt_en),
      .bit_in (streamData[i]),
      .count  (cnt)
    );

    // The last beat is still in flight when latching, so fold its bit in here.
    assign cnt_final = cnt + CW'(streamData[i]);

`ifdef SC_DECODER_BIPOLAR_EN
    assign field_all[i*W +: W] = ({1'b0, cnt_final} << 1) - W'(N);
`else
    assign field_all[i*W +: W] = cnt_final;
`endif
  end

  assign busy      = (state_q == ST_COUNT);
  assign out_valid = (state_q == ST_DONE);
  assign outData   = out_q;

endmodule

// File: tb/tb_sc_matrix_decoder.sv
// tb/tb_sc_matrix_decoder.sv - randomized self-checking bench for sc_matrix_decoder against a ones-count model
module tb_sc_matrix_decoder;

  localparam int M  = 4;
  localparam int O  = 4;
  localparam int L  = 8;
  localparam int N  = 1 << L;
  localparam int NE = M * O;
`ifdef SC_DECODER_BIPOLAR_EN
  localparam int W  = L + 2;
`else
  localparam int W  = L + 1;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [NE-1:0] streamData;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [NE*W-1:0] outData;

  int vectors;
  int miscompares;
  int exp_cnt[NE];

  sc_matrix_decoder #(
    .BATCH_SIZE      (M),
    .OUTPUT_FEATURES (O),
    .LENGTH_LOG2     (L)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .streamData (streamData),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .outData    (outData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint expected_field(input int c);
`ifdef SC_DECODER_BIPOLAR_EN
    return longint'(2 * c - N);
`else
    return longint'(c);
`endif
  endfunction

  function automatic longint observed_field(input int i);
    logic [W-1:0] f;
    f = outData[i*W +: W];
`ifdef SC_DECODER_BIPOLAR_EN
    return longint'($signed(f));
`else
    return longint'(f);
`endif
  endfunction

  task automatic check_fields(input string tag);
    for (int i = 0; i < NE; i++) begin
      check($sformatf("%s_f%0d", tag, i), observed_field(i), expected_field(exp_cnt[i]));
    end
  endtask

  // dmode: 0 all ones, 1 all zeros, 2 directed (0,0)/(3,3) pattern, 3 random
  // vmode: 0 every cycle valid, 1 every third cycle idle, 2 random gaps
  task automatic run_window(input string tag, input int dmode, input int vmode, input bit do_start);
    int beats;
    int cyc;
    logic [NE-1:0] d;
    logic v;
    for (int i = 0; i < NE; i++) exp_cnt[i] = 0;
    if (do_start) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_after_start"}, busy, 1);
    end
    beats = 0;
    cyc   = 0;
    while (beats < N) begin
      if (cyc != 0 || do_start == 1'b0) @(negedge clk);
      cyc++;
      case (vmode)
        1:       v = (cyc % 3) != 0;
        2:       v = ($urandom_range(0, 3) != 0);
        default: v = 1'b1;
      endcase
      case (dmode)
        0:       d = '1;
        1:       d = '0;
        2: begin
          d = NE'($urandom);
          d[0]      = (beats % 2) == 0;
          d[NE-1]   = beats < 64;
        end
        default: d = NE'($urandom);
      endcase
      in_valid   = v;
      streamData = d;
      if (v) begin
        for (int i = 0; i < NE; i++) if (d[i]) exp_cnt[i]++;
        beats++;
        if (beats == N) begin
          check({tag, "_busy_last"}, busy, 1);
          check({tag, "_ovalid_before"}, out_valid, 0);
        end
      end
    end
    @(negedge clk);
    in_valid   = 1'b0;
    streamData = NE'($urandom);
    check({tag, "_ovalid_latency"}, out_valid, 1);
    check({tag, "_busy_done"}, busy, 0);
    check_fields(tag);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_hs", out_valid, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    in_valid    = 1'b0;
    streamData  = '0;
    out_ready   = 1'b0;
    for (int i = 0; i < NE; i++) exp_cnt[i] = 0;

    #12;
    check("rst_busy", busy, 0);
    check("rst_ovalid", out_valid, 0);
    check("rst_data", (outData == '0), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Stream noise while IDLE must not leak into the next window.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid   = 1'b1;
      streamData = NE'($urandom);
      check("idle_busy", busy, 0);
    end
    in_valid = 1'b0;

    run_window("ones", 0, 0, 1'b1);
    handshake();
    run_window("zeros", 1, 0, 1'b1);
    handshake();
    run_window("directed", 2, 0, 1'b1);
    check("dir_f0", observed_field(0), expected_field(128));
    check("dir_f15", observed_field(NE-1), expected_field(64));
    handshake();
    run_window("gap3", 0, 1, 1'b1);
    handshake();
    run_window("rand", 3, 2, 1'b1);

    // Hold in DONE with stimulus toggling; output must not move.
    for (int k = 0; k < 10; k++) begin
      start      = k[0];
      in_valid   = ~k[0];
      streamData = NE'($urandom);
      @(negedge clk);
      check("hold_ovalid", out_valid, 1);
      check("hold_busy", busy, 0);
      check_fields("hold");
    end
    out_ready = 1'b1;
    start     = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check("hs_start_busy", busy, 1);
    check("hs_start_ovalid", out_valid, 0);
    run_window("restart", 3, 2, 1'b0);

    // Abort a window mid-flight with reset; outData still holds the last result here.
    handshake();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      in_valid   = 1'b1;
      streamData = '1;
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_ovalid", out_valid, 0);
    check("abort_data", (outData == '0), 1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_window("post_abort", 3, 0, 1'b1);
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
